// File: rtl/button_event_pkg.sv
// Shared types and helpers for the button event controller: event codes, tracker
// state encoding and the {id, code} event record seen by consumers.
package button_event_pkg;

  typedef enum logic [1:0] {
    EvPress   = 2'd0,
    EvRelease = 2'd1,
    EvLong    = 2'd2,
    EvRepeat  = 2'd3
  } event_code_t;

  typedef logic [1:0] state_t;
  localparam state_t StIdle    = 2'd0;
  localparam state_t StPressed = 2'd1;
  localparam state_t StHeld    = 2'd2;

  // Wide enough for the largest supported button count (16).
  localparam int unsigned MaxIdW = 4;

  typedef struct packed {
    logic [MaxIdW-1:0] id;
    event_code_t       code;
  } event_rec_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_tracker.sv
// Per-button tracker: edge detect, IDLE/PRESSED/HELD FSM, hold counter and a 1-deep
// pending event slot. REPEAT events only exist when BUTTON_EVENT_AUTO_REPEAT_EN is defined.
module button_event_tracker
  import button_event_pkg::*;
#(
  parameter int unsigned G_LONG_PRESS_CYCLES = 1000000,
  parameter int unsigned G_REPEAT_CYCLES     = 200000
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        btn_level,
  input  logic        slot_drain,
  output logic        slot_valid,
  output event_code_t slot_code,
  output logic        drop
);

  localparam int unsigned CntW = $clog2(max_u(G_LONG_PRESS_CYCLES, G_REPEAT_CYCLES));
  localparam logic [CntW-1:0] LongLast = CntW'(G_LONG_PRESS_CYCLES - 1);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam logic [CntW-1:0] RepLast = CntW'(G_REPEAT_CYCLES - 1);
`endif

  state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        level_q;
  logic        slot_valid_q, slot_valid_d;
  event_code_t slot_code_q, slot_code_d;
  logic        ev_fire;
  event_code_t ev_code;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_fire = 1'b0;
    ev_code = EvPress;
    case (state_q)
      StIdle: begin
        if (btn_level && !level_q) begin
          ev_fire = 1'b1;
          ev_code = EvPress;
          cnt_d   = '0;
          state_d = StPressed;
        end
      end
      StPressed: begin
        if (!btn_level) begin
          ev_fire = 1'b1;
          ev_code = EvRelease;
          state_d = StIdle;
        end else if (cnt_q == LongLast) begin
          ev_fire = 1'b1;
          ev_code = EvLong;
          cnt_d   = '0;
          state_d = StHeld;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHeld: begin
        if (!btn_level) begin
          ev_fire = 1'b1;
          ev_code = EvRelease;
          state_d = StIdle;
        end else begin
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
          if (cnt_q == RepLast) begin
            ev_fire = 1'b1;
            ev_code = EvRepeat;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A slot drained by the arbiter this cycle can accept the new event without a drop.
  always_comb begin
    drop         = ev_fire && slot_valid_q && !slot_drain;
    slot_valid_d = slot_valid_q && !slot_drain;
    slot_code_d  = slot_code_q;
    if (ev_fire && !drop) begin
      slot_valid_d = 1'b1;
      slot_code_d  = ev_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_code_q  <= EvPress;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_q      <= btn_level;
      slot_valid_q <= slot_valid_d;
      slot_code_q  <= slot_code_d;
    end
  end

  assign slot_valid = slot_valid_q;
  assign slot_code  = slot_code_q;

endmodule

// File: rtl/button_event_controller.sv
// Button event controller: one tracker per button, round-robin arbiter, FWFT event FIFO.
// Define BUTTON_EVENT_AUTO_REPEAT_EN to enable REPEAT events while a button is held.
module button_event_controller
  import button_event_pkg::*;
#(
  parameter int unsigned G_NUM_BUTTONS       = 4,
  parameter int unsigned G_LONG_PRESS_CYCLES = 1000000,
  parameter int unsigned G_REPEAT_CYCLES     = 200000,
  parameter int unsigned G_FIFO_DEPTH        = 8,
  localparam int unsigned IdW   = (G_NUM_BUTTONS > 1) ? $clog2(G_NUM_BUTTONS) : 1,
  localparam int unsigned AddrW = $clog2(G_FIFO_DEPTH)
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [G_NUM_BUTTONS-1:0] btn_level,
  output logic                     event_valid,
  input  logic                     event_ready,
  output logic [1:0]               event_code,
  output logic [IdW-1:0]           event_id,
  output logic [AddrW:0]           fifo_count,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int unsigned EntryW = IdW + 2;
  localparam int unsigned CountW = AddrW + 1;
  localparam logic [CountW-1:0] FifoFull = CountW'(G_FIFO_DEPTH);
  localparam logic [IdW-1:0]    LastId   = IdW'(G_NUM_BUTTONS - 1);

  logic [G_NUM_BUTTONS-1:0] slot_valid, slot_grant, slot_drop;
  event_code_t              slot_code [G_NUM_BUTTONS];

  for (genvar i = 0; i < G_NUM_BUTTONS; i++) begin : g_trk
    button_event_tracker #(
      .G_LONG_PRESS_CYCLES(G_LONG_PRESS_CYCLES),
      .G_REPEAT_CYCLES    (G_REPEAT_CYCLES)
    ) u_trk (
      .clk       (clk),
      .aresetn   (aresetn),
      .btn_level (btn_level[i]),
      .slot_drain(slot_grant[i]),
      .slot_valid(slot_valid[i]),
      .slot_code (slot_code[i]),
      .drop      (slot_drop[i])
    );
  end

  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic [IdW-1:0]    ptr_q, ptr_d;
  logic              grant_vld;
  logic [IdW-1:0]    grant_idx;
  event_code_t       grant_code;
  logic              overflow_q;

  // Round robin: first full slot at or above the pointer, else the lowest full slot.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_code = EvPress;
    slot_grant = '0;
    if (count_q != FifoFull) begin
      for (int i = 0; i < int'(G_NUM_BUTTONS); i++) begin
        if (!grant_vld && slot_valid[i] && (IdW'(i) >= ptr_q)) begin
          grant_vld     = 1'b1;
          grant_idx     = IdW'(i);
          grant_code    = slot_code[i];
          slot_grant[i] = 1'b1;
        end
      end
      for (int i = 0; i < int'(G_NUM_BUTTONS); i++) begin
        if (!grant_vld && slot_valid[i]) begin
          grant_vld     = 1'b1;
          grant_idx     = IdW'(i);
          grant_code    = slot_code[i];
          slot_grant[i] = 1'b1;
        end
      end
    end
    ptr_d = ptr_q;
    if (grant_vld) ptr_d = (grant_idx == LastId) ? '0 : grant_idx + IdW'(1);
  end

  logic [EntryW-1:0] mem_q [G_FIFO_DEPTH];
  logic [EntryW-1:0] head;
  logic              push, pop;

  assign push = grant_vld;
  assign pop  = event_valid && event_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {grant_idx, grant_code};
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ptr_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (push && !pop)      count_q <= count_q + CountW'(1);
      else if (!push && pop) count_q <= count_q - CountW'(1);
      if (|slot_drop)        overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  // Outputs are forced to zero while empty so stale storage never shows through.
  assign head        = mem_q[rd_ptr_q];
  assign event_valid = (count_q != '0);
  assign event_code  = event_valid ? head[1:0] : 2'b00;
  assign event_id    = event_valid ? head[EntryW-1:2] : '0;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_button_event_controller.sv
// Randomized bench for button_event_controller with a behavioural model (press age,
// pending slots, event queue) plus directed literal checks.
module tb_button_event_controller;

  localparam int N = 4;
  localparam int L = 20;
  localparam int R = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       aresetn;
  logic [3:0] btn_level;
  logic       event_valid, event_ready, overflow, overflow_clr;
  logic [1:0] event_code, event_id;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  button_event_controller #(
    .G_NUM_BUTTONS      (N),
    .G_LONG_PRESS_CYCLES(L),
    .G_REPEAT_CYCLES    (R),
    .G_FIFO_DEPTH       (D)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .btn_level   (btn_level),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_code  (event_code),
    .event_id    (event_id),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  // Model state: age = cycles since PRESS (-1 when released), pending slots, event queue.
  int age [N];
  bit prev [N];
  bit pv [N];
  int pc [N];
  int qid [$];
  int qcode [$];
  int ptr;
  bit m_ovf;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int ev [N];
    bit found;
    bit drop;
    int g;
    if (!aresetn) begin
      for (int i = 0; i < N; i++) begin
        age[i] = -1; prev[i] = 1'b0; pv[i] = 1'b0; pc[i] = 0;
      end
      qid.delete(); qcode.delete();
      ptr = 0; m_ovf = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      ev[i] = -1;
      if (age[i] < 0) begin
        if (btn_level[i] && !prev[i]) begin ev[i] = 0; age[i] = 0; end
      end else if (!btn_level[i]) begin
        ev[i] = 1; age[i] = -1;
      end else begin
        age[i]++;
        if (age[i] == L) ev[i] = 2;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
        else if (age[i] > L && (age[i] - L) % R == 0) ev[i] = 3;
`endif
      end
    end
    found = 1'b0; g = 0;
    if (qid.size() < D) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (!found && pv[j]) begin found = 1'b1; g = j; end
      end
    end
    if (qid.size() > 0 && event_ready) begin
      void'(qid.pop_front()); void'(qcode.pop_front());
    end
    if (found) begin
      qid.push_back(g); qcode.push_back(pc[g]); pv[g] = 1'b0; ptr = (g + 1) % N;
    end
    drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ev[i] >= 0) begin
        if (pv[i]) drop = 1'b1;
        else begin pv[i] = 1'b1; pc[i] = ev[i]; end
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    for (int i = 0; i < N; i++) prev[i] = btn_level[i];
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp("m_valid", {31'd0, event_valid}, (qid.size() > 0) ? 1 : 0);
      cmp("m_count", {29'd0, fifo_count}, qid.size());
      cmp("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      if (qid.size() > 0) begin
        cmp("m_code", {30'd0, event_code}, qcode[0]);
        cmp("m_id", {30'd0, event_id}, qid[0]);
      end else begin
        cmp("m_code_idle", {30'd0, event_code}, 0);
        cmp("m_id_idle", {30'd0, event_id}, 0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int tp, tl, tr;
    int tdiv, rthr;
    aresetn = 1'b0; btn_level = 4'h0; event_ready = 1'b0; overflow_clr = 1'b0;
    chk_en = 1'b1;
    cyc(3);
    cmp("rst_valid", {31'd0, event_valid}, 0);
    cmp("rst_count", {29'd0, fifo_count}, 0);
    cmp("rst_overflow", {31'd0, overflow}, 0);
    cmp("rst_code", {30'd0, event_code}, 0);
    cmp("rst_id", {30'd0, event_id}, 0);
    aresetn = 1'b1;

    // Single short press of button 2: two-cycle latency, then RELEASE.
    btn_level = 4'b0100;
    cyc(1);
    cmp("press_lat_count", {29'd0, fifo_count}, 0);
    cyc(1);
    cmp("press_valid", {31'd0, event_valid}, 1);
    cmp("press_id", {30'd0, event_id}, 2);
    cmp("press_code", {30'd0, event_code}, 0);
    event_ready = 1'b1;
    cyc(3);
    btn_level = 4'b0000;
    cyc(2);
    cmp("release_valid", {31'd0, event_valid}, 1);
    cmp("release_id", {30'd0, event_id}, 2);
    cmp("release_code", {30'd0, event_code}, 1);
    cyc(2);

    // Simultaneous presses from pointer 0, then round-robin continuation.
    aresetn = 1'b0; cyc(1); aresetn = 1'b1;
    btn_level = 4'hF;
    cyc(2);
    for (int k = 0; k < 4; k++) begin
      cmp("rr_press_id", {30'd0, event_id}, k);
      cyc(1);
    end
    btn_level = 4'b1010;
    cyc(2);
    cmp("rr_rel_id_a", {30'd0, event_id}, 0);
    cmp("rr_rel_code_a", {30'd0, event_code}, 1);
    cyc(1);
    cmp("rr_rel_id_b", {30'd0, event_id}, 2);
    btn_level = 4'b0000;
    cyc(2);
    cmp("rr_rel_id_c", {30'd0, event_id}, 3);
    cyc(1);
    cmp("rr_rel_id_d", {30'd0, event_id}, 1);
    cyc(2);

    // Saturate FIFO and slots with ready low, force drops, then clear overflow.
    aresetn = 1'b0; cyc(1); aresetn = 1'b1;
    event_ready = 1'b0;
    btn_level = 4'hF;
    cyc(6);
    cmp("sat_count", {29'd0, fifo_count}, 4);
    btn_level = 4'h0;
    cyc(2);
    cmp("sat_no_ovf_yet", {31'd0, overflow}, 0);
    btn_level = 4'hF;
    cyc(1);
    cmp("sat_overflow", {31'd0, overflow}, 1);
    overflow_clr = 1'b1;
    cyc(1);
    overflow_clr = 1'b0;
    cmp("ovf_cleared", {31'd0, overflow}, 0);
    cmp("sat_count_hold", {29'd0, fifo_count}, 4);

    // Reset with entries queued and buttons mid-LONG count; buttons stay held.
    aresetn = 1'b0;
    cyc(1);
    cmp("mid_rst_valid", {31'd0, event_valid}, 0);
    cmp("mid_rst_count", {29'd0, fifo_count}, 0);
    cmp("mid_rst_overflow", {31'd0, overflow}, 0);
    aresetn = 1'b1;
    btn_level = 4'b0001;
    cyc(1);
    cmp("held_rst_lat", {29'd0, fifo_count}, 0);
    cyc(1);
    cmp("held_rst_valid", {31'd0, event_valid}, 1);
    cmp("held_rst_code", {30'd0, event_code}, 0);
    cmp("held_rst_id", {30'd0, event_id}, 0);

    // LONG / REPEAT timing for button 0.
    aresetn = 1'b0; btn_level = 4'h0; cyc(1); aresetn = 1'b1;
    event_ready = 1'b1;
    btn_level = 4'b0001;
    tp = -1; tl = -1; tr = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (event_valid && event_id == 2'd0) begin
        if (event_code == 2'd0 && tp < 0) tp = c;
        if (event_code == 2'd2 && tl < 0) tl = c;
        if (event_code == 2'd3 && tr < 0) tr = c;
      end
    end
    btn_level = 4'h0;
    cmp("long_delay", tl - tp, L);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    cmp("repeat_delay", tr - tp, L + R);
`else
    cmp("no_repeat", tr, -1);
`endif
    cyc(3);

    // Randomized phases checked by the model process.
    for (int ph = 0; ph < 8; ph++) begin
      tdiv = (ph % 3 == 0) ? 4 : ((ph % 3 == 1) ? 16 : 64);
      rthr = 1 + (ph * 3) % 8;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        for (int b = 0; b < N; b++) begin
          if ($urandom_range(0, tdiv - 1) == 0) btn_level[b] = ~btn_level[b];
        end
        event_ready  = ($urandom_range(0, 7) < rthr);
        overflow_clr = ($urandom_range(0, 31) == 0);
        aresetn      = ($urandom_range(0, 999) != 0);
      end
    end
    aresetn = 1'b1; overflow_clr = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
